ps2_key_tracker: RTL and testbench
==================================

# ps2_key_tracker

Downstream consumer of the PS/2 byte receiver. It takes validated scan-code bytes, each paired with its ROM ASCII value, and runs the make/break/extended protocol. From that it keeps the current held key and a press counter, and drives six seven-segment digits on the board. All state-tracking logic lives here, so the receiver stays a pure byte deframer.

## Interface
Parameters:
- SEG_ACTIVE_LOW, default 1: segment polarity. 1 means a lit segment is driven 0.
- CNT_W, default 8: press-counter width. Displayed digits always show the low 8 bits.

Ports:
- clk  in  1  system clock; the only clock.
- resetn  in  1  reset, synchronous and active-low.
- code_valid  in  1  single-cycle strobe; one received byte.
- code_in  in  8  scan-code byte, valid when code_valid=1.
- ascii_in  in  8  ASCII of code_in from the keymap ROM, valid with code_valid.
- key_code  out  8  scan code of the current/last pressed key.
- key_ascii  out  8  ASCII latched with key_code.
- key_ext  out  1  current key was E0-prefixed.
- key_held  out  1  a key is currently held.
- press_cnt  out  CNT_W  count of distinct presses; wraps.
- hex0..hex5  out  8 each  segment patterns; bit0=a … bit6=g, bit7=dp (dp always off).

## Operation
- Reset (resetn=0 at a clk edge) clears the following and has priority over code_valid:
  - state=IDLE, ext_pend=0.
  - key_code, key_ascii, press_cnt all 0.
  - key_held=0, key_ext=0.
- Prefix bytes:
  - 0xE0 in any state sets ext_pend; state is unchanged.
  - 0xF0 in IDLE or HELD moves to BRK; ext_pend is kept.
- A "key" is the pair {ext_pend, code}. ext_pend clears on every non-prefix byte.
- IDLE, on a non-prefix byte B: latch key_code=B, key_ascii=ascii_in, key_ext=ext_pend; press_cnt+1; key_held=1; go to HELD.
- HELD, on a non-prefix byte B:
  - Same key (typematic repeat): no change.
  - Different key (rollover): re-latch as in IDLE, press_cnt+1.
- BRK:
  - Non-prefix byte matching the current key: key_held=0; go to IDLE. key_code/key_ascii/key_ext are retained.
  - Non-matching byte (release of a rolled-over key): ignored; return to HELD if key_held, else IDLE.
  - 0xF0 in BRK: stay in BRK.
- press_cnt wraps from 2^CNT_W-1 to 0.
- Display:
  - hex1:hex0 = key_code high:low nibble.
  - hex3:hex2 = key_ascii high:low nibble.
  - hex5:hex4 = press_cnt[7:4]:[3:0].
  - hex0–hex3 are blank when key_held=0. hex4/hex5 are always lit.
- Hex glyphs are 0–9 and A–F (lowercase b, d). With active-high encoding: '0'=0x3F, 'C'=0x39, blank=0x00. SEG_ACTIVE_LOW inverts all eight bits.

## Timing
- Register outputs (key_*, press_cnt, state) update on the clk edge where code_valid=1. They are visible the following cycle, giving 1-cycle latency.
- hexN are combinational decodes of the registered values, so they have the same 1-cycle latency. They carry no extra register.
- code_valid held high for k cycles is treated as k bytes. The upstream block guarantees single-cycle pulses.
- Reset values seen on outputs:
  - key_* = 0, press_cnt = 0.
  - hex0–hex3 = blank (0xFF when active-low).
  - hex4 = hex5 = '0' (0xC0 when active-low).
- Reset asserted mid-sequence (e.g. in BRK, or with ext_pend set) discards the partial sequence. The first byte after reset is interpreted from IDLE.

## Structure
- Package ps2_pkg holds:
  - The state enum {IDLE, HELD, BRK}.
  - Constants BREAK_CODE=8'hF0 and EXT_CODE=8'hE0.
  - The 16-entry active-high glyph constants and the SEG_BLANK constant.
- One sub-module, hex7seg: 4-bit value, blank, and polarity in; 8-bit pattern out. It is instantiated six times.
- The top level contains the FSM, the latch registers and the counter.

## Test plan
- Reset then press 'A': bytes 1C,1C,1C,F0,1C.
  - After the first 1C: key_code=0x1C, key_ascii=0x61, press_cnt=1, key_held=1, hex0='C', hex1='1'.
  - After the final 1C: key_held=0, press_cnt=1, hex0–hex3 blank.
- Extended key: E0,74,E0,F0,74 → key_ext=1 and key_code=0x74 while held; released after the final 74; press_cnt=1.
- Rollover: 1C,32,F0,1C,F0,32.
  - After 32: key_code=0x32, press_cnt=2.
  - F0,1C is ignored: still held, code 0x32.
  - F0,32 releases.
- Wrap: 256 press/release pairs of 0x1C from reset → press_cnt=0 and hex5:hex4="00".
- Reset mid-break: 1C,F0, then resetn=0 for one cycle, then 1C → IDLE path taken: key_held=1, press_cnt=1.
- Same-cycle priority: resetn=0 together with code_valid=1 and code_in=0x1C → all outputs at their reset values; press_cnt=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 key tracker:
//   state_t      - make/break tracking states (IDLE, HELD, BRK)
//   BREAK_CODE   - 0xF0 break prefix byte
//   EXT_CODE     - 0xE0 extended-key prefix byte
//   SEG_GLYPH    - active-high seven-segment patterns for 0..F, indexed by value
//   SEG_BLANK    - active-high pattern with every segment off
//   seg_pattern  - glyph lookup with blanking and polarity applied
// Segment bit order: bit0=a ... bit6=g, bit7=dp.
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        BRK  = 2'd2
    } state_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] EXT_CODE   = 8'hE0;
    localparam logic [7:0] SEG_BLANK  = 8'h00;

    // Packed so that SEG_GLYPH[v] is the glyph for value v (element 0 is last).
    localparam logic [15:0][7:0] SEG_GLYPH = {
        8'h71, 8'h79, 8'h5E, 8'h39,   // F E d C
        8'h7C, 8'h77, 8'h6F, 8'h7F,   // b A 9 8
        8'h07, 8'h7D, 8'h6D, 8'h66,   // 7 6 5 4
        8'h4F, 8'h5B, 8'h06, 8'h3F    // 3 2 1 0
    };

    // dp is never set in the active-high table, so inversion leaves it dark.
    function automatic logic [7:0] seg_pattern(input logic [3:0] val,
                                               input logic       blank,
                                               input logic       active_low);
        logic [7:0] pat;
        pat = blank ? SEG_BLANK : SEG_GLYPH[val];
        return pat ^ {8{active_low}};
    endfunction

endpackage

// File: rtl/ps2_key_tracker_hex7seg.sv
// ----------------------------------------------------------------------------
// hex7seg
// Combinational hex-digit to seven-segment decoder.
// Ports:
//   i_val        in  4  nibble to show (0..F)
//   i_blank      in  1  1 = all segments off
//   i_active_low in  1  1 = lit segment driven 0 (all eight bits inverted)
//   o_seg        out 8  bit0=a ... bit6=g, bit7=dp (dp always off)
// ----------------------------------------------------------------------------
module hex7seg
    import ps2_pkg::*;
(
    input  logic [3:0] i_val,
    input  logic       i_blank,
    input  logic       i_active_low,
    output logic [7:0] o_seg
);

    assign o_seg = seg_pattern(i_val, i_blank, i_active_low);

endmodule

// File: rtl/ps2_key_tracker.sv
// ----------------------------------------------------------------------------
// ps2_key_tracker
// Consumes validated PS/2 scan-code bytes, runs the make/break/extended
// protocol, tracks the currently held key and a press counter, and drives
// six seven-segment digits.
// Parameters:
//   SEG_ACTIVE_LOW  1 = lit segment driven 0
//   CNT_W           press counter width (display shows the low 8 bits)
// Ports:
//   clk         in  1      system clock
//   resetn      in  1      synchronous active-low reset (beats code_valid)
//   code_valid  in  1      one received byte this cycle
//   code_in     in  8      scan-code byte
//   ascii_in    in  8      keymap ASCII for code_in
//   key_code    out 8      scan code of current/last pressed key
//   key_ascii   out 8      ASCII latched with key_code
//   key_ext     out 1      current key was E0-prefixed
//   key_held    out 1      a key is currently held
//   press_cnt   out CNT_W  distinct presses, wraps
//   hex0..hex5  out 8      code (1:0), ascii (3:2), press count (5:4)
//   state_dbg   out 2      current protocol state (state_t encoding)
// Handshake: code_valid is a strobe with no back-pressure; every cycle it is
// high consumes one byte, and results are visible the following cycle.
// ----------------------------------------------------------------------------
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int CNT_W          = 8
)(
    input  logic             clk,
    input  logic             resetn,
    input  logic             code_valid,
    input  logic [7:0]       code_in,
    input  logic [7:0]       ascii_in,
    output logic [7:0]       key_code,
    output logic [7:0]       key_ascii,
    output logic             key_ext,
    output logic             key_held,
    output logic [CNT_W-1:0] press_cnt,
    output logic [7:0]       hex0,
    output logic [7:0]       hex1,
    output logic [7:0]       hex2,
    output logic [7:0]       hex3,
    output logic [7:0]       hex4,
    output logic [7:0]       hex5,
    output logic [1:0]       state_dbg
);

    state_t           r_state;
    logic             r_ext_pend;
    logic [7:0]       r_key_code;
    logic [7:0]       r_key_ascii;
    logic             r_key_ext;
    logic             r_key_held;
    logic [CNT_W-1:0] r_press_cnt;

    state_t           w_state_nxt;
    logic             w_ext_pend_nxt;
    logic             w_held_nxt;
    logic             w_latch;
    logic             w_same_key;
    logic [7:0]       w_cnt8;
    logic             w_pol;

    // A key is identified by {extended prefix, code}.
    assign w_same_key = (r_ext_pend == r_key_ext) && (code_in == r_key_code);

    always_comb begin
        w_state_nxt    = r_state;
        w_ext_pend_nxt = r_ext_pend;
        w_held_nxt     = r_key_held;
        w_latch        = 1'b0;
        if (code_valid) begin
            if (code_in == EXT_CODE) begin
                w_ext_pend_nxt = 1'b1;
            end else if (code_in == BREAK_CODE) begin
                // Entered from IDLE or HELD, and a repeated F0 stays here.
                w_state_nxt = BRK;
            end else begin
                w_ext_pend_nxt = 1'b0;
                case (r_state)
                    IDLE: begin
                        w_latch     = 1'b1;
                        w_state_nxt = HELD;
                    end
                    HELD: begin
                        // Typematic repeat of the same key changes nothing.
                        w_latch = !w_same_key;
                    end
                    BRK: begin
                        if (w_same_key) begin
                            w_held_nxt  = 1'b0;
                            w_state_nxt = IDLE;
                        end else begin
                            // Release of a key already rolled over: ignore.
                            w_state_nxt = r_key_held ? HELD : IDLE;
                        end
                    end
                    default: w_state_nxt = IDLE;
                endcase
                if (w_latch) begin
                    w_held_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_ext_pend  <= 1'b0;
            r_key_code  <= 8'h00;
            r_key_ascii <= 8'h00;
            r_key_ext   <= 1'b0;
            r_key_held  <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_ext_pend <= w_ext_pend_nxt;
            r_key_held <= w_held_nxt;
            if (w_latch) begin
                r_key_code  <= code_in;
                r_key_ascii <= ascii_in;
                r_key_ext   <= r_ext_pend;
                r_press_cnt <= r_press_cnt + CNT_W'(1);
            end
        end
    end

    assign key_code  = r_key_code;
    assign key_ascii = r_key_ascii;
    assign key_ext   = r_key_ext;
    assign key_held  = r_key_held;
    assign press_cnt = r_press_cnt;
    assign state_dbg = r_state;

    assign w_cnt8 = 8'(r_press_cnt);
    assign w_pol  = (SEG_ACTIVE_LOW != 0);

    hex7seg u_hex0 (.i_val(r_key_code[3:0]),  .i_blank(!r_key_held), .i_active_low(w_pol), .o_seg(hex0));
    hex7seg u_hex1 (.i_val(r_key_code[7:4]),  .i_blank(!r_key_held), .i_active_low(w_pol), .o_seg(hex1));
    hex7seg u_hex2 (.i_val(r_key_ascii[3:0]), .i_blank(!r_key_held), .i_active_low(w_pol), .o_seg(hex2));
    hex7seg u_hex3 (.i_val(r_key_ascii[7:4]), .i_blank(!r_key_held), .i_active_low(w_pol), .o_seg(hex3));
    hex7seg u_hex4 (.i_val(w_cnt8[3:0]),      .i_blank(1'b0),        .i_active_low(w_pol), .o_seg(hex4));
    hex7seg u_hex5 (.i_val(w_cnt8[7:4]),      .i_blank(1'b0),        .i_active_low(w_pol), .o_seg(hex5));

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;

    localparam int W = 26;  // {code, ascii, ext, held, cnt}

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic [7:0] ascii_in = 8'h00;
    logic [7:0] key_code, key_ascii;
    logic       key_ext, key_held;
    logic [7:0] press_cnt;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];

    // Reference model state
    logic       m_held, m_brk, m_ext_pend, m_ext;
    logic [7:0] m_code, m_ascii, m_cnt;

    ps2_key_tracker #(.SEG_ACTIVE_LOW(1), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn), .code_valid(code_valid),
        .code_in(code_in), .ascii_in(ascii_in),
        .key_code(key_code), .key_ascii(key_ascii), .key_ext(key_ext),
        .key_held(key_held), .press_cnt(press_cnt),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Active-low glyph as the board sees it.
    function automatic logic [7:0] seg_al(input logic [3:0] v, input logic blank);
        logic [7:0] p;
        if (blank) p = 8'h00;
        else begin
            case (v)
                4'h0: p = 8'h3F; 4'h1: p = 8'h06; 4'h2: p = 8'h5B; 4'h3: p = 8'h4F;
                4'h4: p = 8'h66; 4'h5: p = 8'h6D; 4'h6: p = 8'h7D; 4'h7: p = 8'h07;
                4'h8: p = 8'h7F; 4'h9: p = 8'h6F; 4'hA: p = 8'h77; 4'hB: p = 8'h7C;
                4'hC: p = 8'h39; 4'hD: p = 8'h5E; 4'hE: p = 8'h79; default: p = 8'h71;
            endcase
        end
        return ~p;
    endfunction

    function automatic logic [7:0] ascii_of(input logic [7:0] c);
        case (c)
            8'h1C: return 8'h61;
            8'h32: return 8'h62;
            8'h74: return 8'h36;
            8'h23: return 8'h64;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_held = 0; m_brk = 0; m_ext_pend = 0; m_ext = 0;
        m_code = 0; m_ascii = 0; m_cnt = 0;
    endtask

    task automatic model_byte(input logic [7:0] c, input logic [7:0] a);
        logic same;
        if (c == 8'hE0) m_ext_pend = 1;
        else if (c == 8'hF0) m_brk = 1;
        else begin
            same = (m_ext_pend == m_ext) && (c == m_code);
            if (m_brk) begin
                m_brk = 0;
                if (same) m_held = 0;
            end else if (!m_held || !same) begin
                m_code = c; m_ascii = a; m_ext = m_ext_pend;
                m_cnt = m_cnt + 8'd1; m_held = 1;
            end
            m_ext_pend = 0;
        end
    endtask

    // Scoreboard: pop the expected entry and compare every output.
    task automatic compare_outputs();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check("queue_underflow", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("key_code",  key_code,  e[25:18]);
        check("key_ascii", key_ascii, e[17:10]);
        check("key_ext",   key_ext,   e[9]);
        check("key_held",  key_held,  e[8]);
        check("press_cnt", press_cnt, e[7:0]);
        check("hex0", hex0, seg_al(e[21:18], !e[8]));
        check("hex1", hex1, seg_al(e[25:22], !e[8]));
        check("hex2", hex2, seg_al(e[13:10], !e[8]));
        check("hex3", hex3, seg_al(e[17:14], !e[8]));
        check("hex4", hex4, seg_al(e[3:0], 1'b0));
        check("hex5", hex5, seg_al(e[7:4], 1'b0));
    endtask

    // driver tasks
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        code_valid = 1; code_in = c; ascii_in = ascii_of(c);
        model_byte(c, ascii_of(c));
        exp_q.push_back({m_code, m_ascii, m_ext, m_held, m_cnt});
        @(posedge clk); #1;
        code_valid = 0;
        compare_outputs();
    endtask

    task automatic do_reset(input logic with_valid);
        @(negedge clk);
        resetn = 0; code_valid = with_valid; code_in = 8'h1C; ascii_in = 8'h61;
        model_reset();
        exp_q.push_back({m_code, m_ascii, m_ext, m_held, m_cnt});
        @(posedge clk); #1;
        resetn = 1; code_valid = 0;
        compare_outputs();
        check("rst_hex0", hex0, 8'hFF);
        check("rst_hex3", hex3, 8'hFF);
        check("rst_hex4", hex4, 8'hC0);
        check("rst_hex5", hex5, 8'hC0);
        check("rst_cnt",  press_cnt, 8'h00);
    endtask

    initial begin
        logic [7:0] pool [5];
        pool[0] = 8'h1C; pool[1] = 8'h32; pool[2] = 8'h74; pool[3] = 8'hE0; pool[4] = 8'hF0;

        repeat (2) @(posedge clk);
        do_reset(1'b0);

        // Press and release 'A' with typematic repeats
        send(8'h1C);
        check("a_code", key_code, 8'h1C);
        check("a_ascii", key_ascii, 8'h61);
        check("a_hex0_C", hex0, 8'hC6);
        check("a_hex1_1", hex1, 8'hF9);
        send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C);
        check("a_released", key_held, 1'b0);
        check("a_cnt", press_cnt, 8'd1);
        check("a_hex2_blank", hex2, 8'hFF);

        // Extended key
        do_reset(1'b0);
        send(8'hE0); send(8'h74);
        check("ext_flag", key_ext, 1'b1);
        check("ext_code", key_code, 8'h74);
        send(8'hE0); send(8'hF0); send(8'h74);
        check("ext_released", key_held, 1'b0);
        check("ext_cnt", press_cnt, 8'd1);

        // Rollover
        do_reset(1'b0);
        send(8'h1C); send(8'h32);
        check("roll_code", key_code, 8'h32);
        check("roll_cnt", press_cnt, 8'd2);
        send(8'hF0); send(8'h1C);
        check("roll_ignore_held", key_held, 1'b1);
        check("roll_ignore_code", key_code, 8'h32);
        send(8'hF0); send(8'h32);
        check("roll_release", key_held, 1'b0);

        // Counter wrap
        do_reset(1'b0);
        for (int i = 0; i < 256; i++) begin
            send(8'h1C); send(8'hF0); send(8'h1C);
        end
        check("wrap_cnt", press_cnt, 8'd0);
        check("wrap_hex4", hex4, 8'hC0);
        check("wrap_hex5", hex5, 8'hC0);

        // Random byte stream from a small pool
        do_reset(1'b0);
        for (int i = 0; i < 300; i++) send(pool[$urandom_range(0, 4)]);

        // Reset mid-break: first byte afterwards starts from IDLE
        do_reset(1'b0);
        send(8'h1C); send(8'hF0);
        do_reset(1'b0);
        send(8'h1C);
        check("midbrk_held", key_held, 1'b1);
        check("midbrk_cnt", press_cnt, 8'd1);

        // Reset with ext pending discards the prefix
        send(8'hE0);
        do_reset(1'b0);
        send(8'h74);
        check("midext_ext", key_ext, 1'b0);

        // Reset beats a simultaneous byte
        do_reset(1'b1);
        check("prio_held", key_held, 1'b0);
        check("prio_code", key_code, 8'h00);

        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
